// File: rtl/mmio_port_responder_pkg.sv
// Shared constants for the MMIO responder: register word offsets, STATUS/CTRL
// bit positions and the default window base.
package mmio_pkg;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    // Word offsets (Address[4:2]); byte offset = 4 * value.
    localparam logic [2:0] OFS_PORT_OUT  = 3'd0;
    localparam logic [2:0] OFS_PORT_IN   = 3'd1;
    localparam logic [2:0] OFS_STATUS    = 3'd2;
    localparam logic [2:0] OFS_TMR_LOAD  = 3'd3;
    localparam logic [2:0] OFS_CTRL      = 3'd4;
    localparam logic [2:0] OFS_TMR_COUNT = 3'd5;

    localparam int ST_IN_CHANGED  = 0;
    localparam int ST_TMR_EXPIRED = 1;

    localparam int CTRL_TMR_EN      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IE_IN       = 2;
    localparam int CTRL_IE_TMR      = 3;

    typedef struct packed {
        logic ie_tmr;
        logic ie_in;
        logic auto_reload;
        logic tmr_en;
    } ctrl_t;
endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus seen by the MMIO responder (lw/sw side of the datapath).
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (output Address, WriteData, MemWrite, MemRead,
                    input  ReadData, Hit);
    modport slave  (input  Address, WriteData, MemWrite, MemRead,
                    output ReadData, Hit);
endinterface

// File: rtl/mmio_port_responder_sync.sv
// Multi-flop synchronizer for the external input port, plus a one-cycle
// delayed copy used to detect changes of the synchronized value.
module port_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_in,
    output logic [7:0] sync_in,
    output logic       change
);
    // sync_q[0] is the first (metastable) stage, sync_q[SYNC_STAGES-1] the output.
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  prev_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            prev_in <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], port_in};
            prev_in <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign change  = (sync_in != prev_in);
endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: GPIO out register, synchronized input port with change flag,
// down-counting timer with sticky expiry, and a level interrupt.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    mmio_port_responder_if.slave        bus,
    input  logic [7:0]                  PortIn,
    output logic [31:0]                 PortOut,
    output logic                        Irq
);
    logic [2:0]  ofs;
    logic        wr;
    logic [7:0]  sync_in;
    logic        in_change;
    logic [31:0] tmr_load;
    logic [31:0] tmr_count, tmr_count_nxt;
    ctrl_t       ctrl;
    logic [1:0]  status, status_nxt;
    logic        expire;
    logic [31:0] rd_data;

    assign bus.Hit = (bus.Address[31:5] == BASE_ADDR[31:5]) && (bus.Address[1:0] == 2'b00);
    assign ofs     = bus.Address[4:2];
    assign wr      = bus.MemWrite && bus.Hit;

    port_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .port_in (PortIn),
        .sync_in (sync_in),
        .change  (in_change)
    );

    // Counter step uses the registered CTRL; a TIMER_LOAD write overrides the
    // step and swallows any expiry from the same cycle.
    always_comb begin
        expire        = 1'b0;
        tmr_count_nxt = tmr_count;
        if (ctrl.tmr_en && tmr_count != 32'd0) begin
            if (tmr_count == 32'd1) begin
                expire        = 1'b1;
                tmr_count_nxt = (ctrl.auto_reload && tmr_load != 32'd0) ? tmr_load : 32'd0;
            end else begin
                tmr_count_nxt = tmr_count - 32'd1;
            end
        end
        if (wr && ofs == OFS_TMR_LOAD) begin
            expire        = 1'b0;
            tmr_count_nxt = bus.WriteData;
        end
    end

    // W1C first, then set events, so a set in the clearing cycle wins.
    always_comb begin
        status_nxt = status;
        if (wr && ofs == OFS_STATUS)
            status_nxt = status & ~bus.WriteData[1:0];
        if (in_change)
            status_nxt[ST_IN_CHANGED] = 1'b1;
        if (expire)
            status_nxt[ST_TMR_EXPIRED] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            PortOut   <= '0;
            tmr_load  <= '0;
            tmr_count <= '0;
            ctrl      <= '0;
            status    <= '0;
        end else begin
            if (wr && ofs == OFS_PORT_OUT) PortOut  <= bus.WriteData;
            if (wr && ofs == OFS_TMR_LOAD) tmr_load <= bus.WriteData;
            if (wr && ofs == OFS_CTRL)     ctrl     <= ctrl_t'(bus.WriteData[3:0]);
            tmr_count <= tmr_count_nxt;
            status    <= status_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.MemRead && bus.Hit) begin
            case (ofs)
                OFS_PORT_OUT:  rd_data = PortOut;
                OFS_PORT_IN:   rd_data = {24'b0, sync_in};
                OFS_STATUS:    rd_data = {30'b0, status};
                OFS_TMR_LOAD:  rd_data = tmr_load;
                OFS_CTRL:      rd_data = {28'b0, ctrl};
                OFS_TMR_COUNT: rd_data = tmr_count;
                default:       rd_data = '0;
            endcase
        end
    end
    assign bus.ReadData = rd_data;

    assign Irq = (status[ST_IN_CHANGED]  && ctrl.ie_in) ||
                 (status[ST_TMR_EXPIRED] && ctrl.ie_tmr);
endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus: the slave end of the lw/sw interface.
- Decodes a 32-byte window and implements a GPIO output register, a synchronized 8-bit input port with change detection, and a down-counting timer with sticky status and an interrupt line.
- Sits beside DataMemory. Top level selects ReadData from this block when Hit=1, else from RAM.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, window base; must be 32-byte aligned.
- SYNC_STAGES, 2, flops in the PortIn synchronizer (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Address  input  32  byte address from ALU result.
- WriteData  input  32  store data (rt value).
- MemWrite  input  1  store strobe, sampled on the rising edge.
- MemRead  input  1  load strobe.
- ReadData  output  32  load data, combinational.
- Hit  output  1  Address falls in window and is word-aligned.
- PortIn  input  8  asynchronous external input.
- PortOut  output  32  GPIO output register.
- Irq  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-low. Every register is cleared at the clk edge where reset==0.
- Outputs after reset: PortOut=0, Irq=0, STATUS=0, CTRL=0, TIMER_LOAD=0, TIMER_COUNT=0, synchronizer flops=0.
- Decode: Hit = (Address[31:5]==BASE_ADDR[31:5]) && (Address[1:0]==0). Offset is Address[4:2].
- Register map (byte offsets):
  - 0x00 PORT_OUT: RW.
  - 0x04 PORT_IN: RO, {24'b0, sync_in}.
  - 0x08 STATUS: bit0 in_changed, bit1 tmr_expired; write-1-to-clear.
  - 0x0C TIMER_LOAD: RW.
  - 0x10 CTRL: bit0 tmr_en, bit1 auto_reload, bit2 ie_in, bit3 ie_tmr; bits 31:4 read 0.
  - 0x14 TIMER_COUNT: RO.
  - 0x18, 0x1C: read 0, writes ignored.
- Reads: ReadData = register value when MemRead && Hit, else 0. Zero latency, so the single-cycle datapath gets it within the same cycle. Reads have no side effects.
- Writes: take effect at the clk edge when MemWrite && Hit. No effect when Hit=0, including misaligned addresses.
- Synchronizer: PortIn passes through SYNC_STAGES flops to give sync_in; prev_in is sync_in delayed by one cycle.
  - in_changed sets on the edge after sync_in != prev_in.
  - PORT_IN reflects a new PortIn value SYNC_STAGES edges after it is applied.
- Timer load: a write to TIMER_LOAD loads both TIMER_LOAD and TIMER_COUNT with WriteData.
- Timer counting, when tmr_en=1 and TIMER_COUNT != 0:
  - TIMER_COUNT decrements by 1 each cycle.
  - On the 1->0 step, tmr_expired sets.
  - If auto_reload=1 and TIMER_LOAD != 0, that same edge loads TIMER_COUNT=TIMER_LOAD instead of 0, and tmr_expired still sets.
- Timer holding: tmr_en=0 holds TIMER_COUNT; TIMER_COUNT=0 with no reload stays at 0 and raises no new expiry.
- Irq = (in_changed && ie_in) || (tmr_expired && ie_tmr). Registered flags, combinational OR; no extra latency beyond the flags.
- Simultaneous events:
  - A status set event and a W1C of the same bit in one cycle: set wins, bit stays 1.
  - A TIMER_LOAD write in an expiry cycle: the load wins and the expiry is discarded.
  - A CTRL write takes effect from the next cycle; the counter step in the write cycle uses the old CTRL.
- Reset while the timer is running clears everything, including any pending Irq, at that edge.

Decomposition:
- Shared package mmio_pkg:
  - register offset constants (OFS_PORT_OUT, OFS_PORT_IN, OFS_STATUS, OFS_TMR_LOAD, OFS_CTRL, OFS_TMR_COUNT);
  - STATUS/CTRL bit-index constants;
  - default BASE_ADDR.
- One sub-module, port_in_sync: SYNC_STAGES-deep synchronizer plus previous-value register, with outputs sync_in and change pulse.
- Timer and register file stay in the top.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> PortOut=0, Irq=0, and every register reads 0 at 0xFFFF_0000..0xFFFF_0014.
- sw 0xDEADBEEF to 0xFFFF_0000 -> PortOut=0xDEADBEEF the next cycle. The same store to 0x1001_0000 or 0xFFFF_0002 -> Hit=0 and PortOut unchanged.
- PortIn steps 0x00->0x5A -> PORT_IN reads 0x0000005A two edges later and STATUS bit0=1 one edge after that. With ie_in=1, Irq=1. sw 0x1 to STATUS -> bit0=0 and Irq=0.
- TIMER_LOAD=3, CTRL=0x9 -> TIMER_COUNT reads 3,2,1,0 on successive cycles, tmr_expired=1 and Irq=1 after the third edge, then TIMER_COUNT stays 0. With CTRL=0xB -> the count reloads to 3 and repeats; every 3rd cycle is an expiry.
- W1C of bit1 in the exact cycle TIMER_COUNT steps 1->0 -> tmr_expired remains 1. A TIMER_LOAD=5 write in that cycle -> TIMER_COUNT=5 and no expiry flagged.
- reset=0 asserted mid-count with Irq=1 -> at the next edge TIMER_COUNT=0, STATUS=0, Irq=0, and the timer does not restart after release.
